// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Writes and scoreboard updates are clocked; reads and hazard flags are combinational.
module reg_file_sb #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_addr,
  output logic [AW:0]       npend
);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic [AW:0]      npend_q;
  logic [AW:0]      npend_d;
  logic             wr_ok;
  logic             iss_ok;
  logic [AW-1:0]    ra;

  // An address is usable when it is in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = we && addr_ok(waddr);
  assign iss_ok = issue_en && addr_ok(issue_addr);

  // Issue is applied after writeback so a newer producer keeps the register pending.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[waddr]  = wdata;
      pend_d[waddr] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[issue_addr] = 1'b1;
    end
    npend_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      npend_d = npend_d + {{AW{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      pend_q  <= '0;
      npend_q <= '0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      npend_q <= npend_d;
    end
  end

  // Bypass is gated by rst_n so a write presented during reset cannot leak out.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = raddr[i*AW +: AW];
      if (rst_n && addr_ok(ra)) begin
        if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
          rdata[i*DW +: DW] = wdata;
        end else begin
          rdata[i*DW +: DW] = mem_q[ra];
          rbusy[i]          = pend_q[ra];
        end
      end
    end
  end

  assign npend = npend_q;

endmodule
